// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
//   Shared definitions for the pipeline stall/flush controller:
//   - state_t   : controller FSM encoding (2 bits)
//   - PC_SEL_*  : PC source select codes driven on pc_sel
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    S_INIT        = 2'd0,
    S_RUN         = 2'd1,
    S_FREEZE      = 2'd2,
    S_FREEZE_PEND = 2'd3
  } state_t;

  localparam logic [1:0] PC_SEL_SEQ = 2'b00;  // PC+4 / predicted target
  localparam logic [1:0] PC_SEL_BR  = 2'b01;  // mispredict recovery target
  localparam logic [1:0] PC_SEL_JMP = 2'b10;  // ID-stage jump target

endpackage

// File: rtl/pipeline_ctrl_perf.sv
// pipeline_ctrl_perf
//   Stall and redirect statistics for pipeline_ctrl. Built only when
//   PIPELINE_CTRL_PERF_EN is defined. Both counters wrap modulo 2^CNT_W.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   stall_ev    : count one stalled cycle (pc_we=0 outside S_INIT)
//   flush_ev    : count one redirect (pc_we=1 with a non-sequential pc_sel)
//   stall_cnt   : accumulated stalled cycles
//   flush_cnt   : accumulated redirects
module pipeline_ctrl_perf #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_ev,
  input  logic             flush_ev,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_ev) stall_cnt <= stall_cnt + 1'b1;
      if (flush_ev) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Resolves the hazard stall, cache stalls, branch mispredict and ID jump
//   redirect by priority into per-stage write enables, flush/bubble controls
//   and the PC source select of a 5-stage MIPS pipeline. A mispredict that
//   arrives during a cache freeze is held and replayed when the freeze ends.
//   A watchdog raises a sticky hz_timeout on an over-long hazard stall.
//   Optional statistics counters are built when PIPELINE_CTRL_PERF_EN is
//   defined; otherwise stall_cnt/flush_cnt are tied to 0.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   hz_stall                   : hazard-unit stall request (level)
//   icache_stall, dcache_stall : cache misses in progress (level)
//   mispredict                 : one-cycle EX mispredict pulse
//   jump_id                    : jump decoded in ID (level)
//   pc_we, ifid_we, exmem_we, memwb_we : stage write enables
//   ifid_flush                 : IF/ID cleared to NOP
//   idex_bubble                : ID/EX loads NOP
//   pc_sel                     : PC source (see PC_SEL_* in the package)
//   hz_timeout                 : sticky hazard-stall watchdog flag
//   stall_cnt, flush_cnt       : statistics (0 when the feature is off)
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MAX_HAZ_STALL = 4,
  parameter int CNT_W         = 32,
  parameter int WD_W          = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hz_stall,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  input  logic             mispredict,
  input  logic             jump_id,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic [1:0]       pc_sel,
  output logic             hz_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MAX_HAZ_STALL + 1);

  state_t          state, state_nxt;
  logic            cache_stall;
  logic            hz_taken;
  logic [WD_W-1:0] hz_run, hz_run_nxt;

  assign cache_stall = icache_stall | dcache_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_we    = 1'b0;
    memwb_we    = 1'b0;
    pc_sel      = PC_SEL_SEQ;
    hz_taken    = 1'b0;
    unique case (state)
      S_INIT: state_nxt = S_RUN;
      // S_FREEZE decodes exactly like S_RUN once both caches are released,
      // so the two states share one decoder.
      S_RUN, S_FREEZE: begin
        if (cache_stall) begin
          state_nxt = mispredict ? S_FREEZE_PEND : S_FREEZE;
        end else begin
          state_nxt = S_RUN;
          exmem_we  = 1'b1;
          memwb_we  = 1'b1;
          if (mispredict) begin
            // Younger hz_stall/jump_id belong to the wrong path.
            pc_we       = 1'b1;
            ifid_we     = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            pc_sel      = PC_SEL_BR;
          end else if (hz_stall) begin
            // Jump waits in IF/ID; it is taken once the stall clears.
            idex_bubble = 1'b1;
            hz_taken    = (state == S_RUN);
          end else if (jump_id) begin
            pc_we      = 1'b1;
            ifid_we    = 1'b1;
            ifid_flush = 1'b1;
            pc_sel     = PC_SEL_JMP;
          end else begin
            pc_we   = 1'b1;
            ifid_we = 1'b1;
          end
        end
      end
      // Further mispredict pulses here are absorbed: one redirect only.
      S_FREEZE_PEND: begin
        if (!cache_stall) begin
          state_nxt   = S_RUN;
          pc_we       = 1'b1;
          ifid_we     = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          exmem_we    = 1'b1;
          memwb_we    = 1'b1;
          pc_sel      = PC_SEL_BR;
        end
      end
      default: state_nxt = S_INIT;
    endcase
  end

  // Watchdog: consecutive S_RUN hazard-stall cycles, saturating.
  always_comb begin
    hz_run_nxt = '0;
    if (hz_taken) hz_run_nxt = (hz_run == '1) ? hz_run : hz_run + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hz_run     <= '0;
      hz_timeout <= 1'b0;
    end else begin
      hz_run <= hz_run_nxt;
      if (hz_run_nxt >= WD_LIMIT) hz_timeout <= 1'b1;
    end
  end

`ifdef PIPELINE_CTRL_PERF_EN
  pipeline_ctrl_perf #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall_ev  ((state != S_INIT) && !pc_we),
    .flush_ev  (pc_we && (pc_sel != PC_SEL_SEQ)),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
//   Directed bench for pipeline_ctrl: table-driven single-cycle vectors plus
//   hand-written multi-cycle sequences (freeze with pending mispredict,
//   watchdog, asynchronous reset during a pending redirect).
module tb_pipeline_ctrl;

  localparam int CNT_W = 32;

  // Input pattern bits: {hz_stall, icache_stall, dcache_stall, mispredict, jump_id}
  localparam logic [4:0] I_IDLE = 5'b00000;
  localparam logic [4:0] I_HZ   = 5'b10000;
  localparam logic [4:0] I_IC   = 5'b01000;
  localparam logic [4:0] I_DC   = 5'b00100;
  localparam logic [4:0] I_MP   = 5'b00010;
  localparam logic [4:0] I_JMP  = 5'b00001;

  // Output pattern bits: {pc_we, ifid_we, ifid_flush, idex_bubble,
  //                       exmem_we, memwb_we, pc_sel[1:0], hz_timeout}
  localparam logic [8:0] O_ZERO = 9'b0_0_0_0_0_0_00_0;
  localparam logic [8:0] O_NORM = 9'b1_1_0_0_1_1_00_0;
  localparam logic [8:0] O_BR   = 9'b1_1_1_1_1_1_01_0;
  localparam logic [8:0] O_HZ   = 9'b0_0_0_1_1_1_00_0;
  localparam logic [8:0] O_JMP  = 9'b1_1_1_0_1_1_10_0;

  typedef struct {
    logic [4:0] in;
    logic [8:0] exp;
    string      name;
  } vec_t;

  logic             clk;
  logic             rst_n;
  logic             hz_stall, icache_stall, dcache_stall, mispredict, jump_id;
  logic             pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_we;
  logic [1:0]       pc_sel;
  logic             hz_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int               checks;
  int               failures;
  logic [CNT_W-1:0] exp_stall;
  logic [CNT_W-1:0] exp_flush;
  logic             exp_to;
  vec_t             vec_q[$];

  pipeline_ctrl #(
    .MAX_HAZ_STALL (4),
    .CNT_W         (CNT_W),
    .WD_W          (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hz_stall     (hz_stall),
    .icache_stall (icache_stall),
    .dcache_stall (dcache_stall),
    .mispredict   (mispredict),
    .jump_id      (jump_id),
    .pc_we        (pc_we),
    .ifid_we      (ifid_we),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .exmem_we     (exmem_we),
    .memwb_we     (memwb_we),
    .pc_sel       (pc_sel),
    .hz_timeout   (hz_timeout),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [4:0] in);
    {hz_stall, icache_stall, dcache_stall, mispredict, jump_id} = in;
  endtask

  // Compare outputs and counters; then advance the counter model using the
  // expected outputs of this cycle (counters update on the next edge).
  task automatic check(input string name, input logic [8:0] e, input bit init_cycle);
    logic [8:0] act;
    act = {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_we, pc_sel, hz_timeout};
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s: outputs=%b expected=%b", name, act, e);
    end
    checks++;
    if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
      failures++;
      $display("FAIL %s_cnt: stall_cnt=%0d flush_cnt=%0d expected %0d/%0d",
               name, stall_cnt, flush_cnt, exp_stall, exp_flush);
    end
`ifdef PIPELINE_CTRL_PERF_EN
    if (!init_cycle && !e[8]) exp_stall = exp_stall + 1'b1;
    if (e[8] && e[2:1] != 2'b00) exp_flush = exp_flush + 1'b1;
`else
    if (init_cycle) exp_stall = '0;
`endif
  endtask

  // One cycle: drive just after the rising edge, sample on the falling edge.
  task automatic run(input logic [4:0] in, input logic [8:0] e, input string name);
    @(posedge clk);
    #1;
    drive(in);
    @(negedge clk);
    check(name, e | {8'b0, exp_to}, 1'b0);
  endtask

  task automatic add_vec(input logic [4:0] in, input logic [8:0] e, input string name);
    vec_t v;
    v.in   = in;
    v.exp  = e;
    v.name = name;
    vec_q.push_back(v);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    exp_stall = '0;
    exp_flush = '0;
    exp_to    = 1'b0;
    rst_n     = 1'b0;
    drive(I_IDLE);

    // Single-cycle vectors, applied back to back from S_RUN.
    add_vec(I_IDLE,              O_NORM, "idle");
    add_vec(I_HZ,                O_HZ,   "hz_1");
    add_vec(I_HZ,                O_HZ,   "hz_2");
    add_vec(I_IDLE,              O_NORM, "hz_release");
    add_vec(I_JMP,               O_JMP,  "jump");
    add_vec(I_HZ | I_JMP,        O_HZ,   "hz_defers_jump");
    add_vec(I_JMP,               O_JMP,  "deferred_jump");
    add_vec(I_MP | I_HZ | I_JMP, O_BR,   "mp_wins_all");
    add_vec(I_IDLE,              O_NORM, "no_deferred_jump");
    add_vec(I_IC,                O_ZERO, "icache_freeze");
    add_vec(I_IC | I_DC,         O_ZERO, "both_freeze");
    add_vec(I_JMP,               O_JMP,  "freeze_exit_jump");
    add_vec(I_IDLE,              O_NORM, "idle_2");
    add_vec(I_DC | I_MP,         O_ZERO, "freeze_mp");
    add_vec(I_DC,                O_ZERO, "pend_hold");
    add_vec(I_DC | I_MP,         O_ZERO, "pend_second_mp");
    add_vec(I_IDLE,              O_BR,   "pend_redirect");
    add_vec(I_IDLE,              O_NORM, "single_redirect");
    add_vec(I_IC,                O_ZERO, "icache_freeze_2");
    add_vec(I_MP,                O_BR,   "freeze_exit_mp");
    add_vec(I_IDLE,              O_NORM, "idle_3");
    add_vec(I_IC,                O_ZERO, "icache_freeze_3");
    add_vec(I_HZ,                O_HZ,   "freeze_exit_hz");
    add_vec(I_IDLE,              O_NORM, "idle_4");

    // Reset and release: S_INIT cycle, then normal flow.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("in_reset", O_ZERO, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("init_cycle", O_ZERO, 1'b1);
    run(I_IDLE, O_NORM, "first_run");

    for (int i = 0; i < vec_q.size(); i++) begin
      run(vec_q[i].in, vec_q[i].exp, vec_q[i].name);
    end

    // dcache freeze for 5 cycles, mispredict on freeze cycle 2.
    run(I_DC,        O_ZERO, "dc_frz_1");
    run(I_DC | I_MP, O_ZERO, "dc_frz_2");
    for (int k = 3; k <= 5; k++) run(I_DC, O_ZERO, "dc_frz_n");
    run(I_IDLE, O_BR,   "dc_frz_redirect");

    // Watchdog: 6 consecutive hazard-stall cycles, MAX_HAZ_STALL=4.
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) exp_to = 1'b1;
      run(I_HZ, O_HZ, "hz_watchdog");
    end
    run(I_IDLE, O_NORM, "wd_sticky_1");
    run(I_JMP,  O_JMP,  "wd_sticky_2");

    // Asynchronous reset in the middle of S_FREEZE_PEND.
    run(I_DC | I_MP, O_ZERO, "pend_enter");
    run(I_DC,        O_ZERO, "pend_wait");
    #2;
    rst_n = 1'b0;
    #1;
    exp_stall = '0;
    exp_flush = '0;
    exp_to    = 1'b0;
    check("async_reset", O_ZERO, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(I_IDLE);
    @(negedge clk);
    check("post_reset_init", O_ZERO, 1'b1);
    run(I_IDLE, O_NORM, "post_reset_run");
    run(I_IDLE, O_NORM, "post_reset_run_2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
